// File: rtl/mod_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mod_mem_arbiter_pkg
// Shared system definitions for the memory arbiter slice:
//   SYS_XLEN / SYS_BYTEENABLE_WIDTH : default address/data and byte-enable widths
//   MAX_CH                          : largest supported requester count
//   arb_state_e                     : arbiter FSM state encoding
//   grant_idx_width()               : grant-index width, $clog2(n) with a floor of 1
// ---------------------------------------------------------------------------
package mod_mem_arbiter_pkg;

  localparam int SYS_XLEN             = 32;
  localparam int SYS_BYTEENABLE_WIDTH = SYS_XLEN / 8;
  localparam int MAX_CH               = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // A single channel still needs a one-bit index to keep port widths legal.
  function automatic int grant_idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mod_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mod_rr_arbiter
// Purely combinational requester picker.
//   req   : eligible requesters (one bit per channel)
//   ptr   : round-robin start index (ignored in fixed-priority mode)
//   mode  : 1 = first eligible at or after ptr (wrapping), 0 = lowest index
//   grant : one-hot winner
//   idx   : binary index of the winner
//   valid : at least one requester was eligible
// ---------------------------------------------------------------------------
module mod_rr_arbiter
  import mod_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = grant_idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    int   start_idx;
    logic found;
    grant     = '0;
    idx       = '0;
    found     = 1'b0;
    start_idx = mode ? int'(ptr) : 0;
    if (start_idx >= NUM_CH) start_idx = 0;
    // Wrapping search split into two linear passes: [start..N-1] then [0..start-1].
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= start_idx)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i < start_idx)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/mod_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mod_mem_arbiter
// Shares one Wishbone B4 classic master port between NUM_CH requesters.
// Handshake: a requester raises req_stb_i[c] (level) with addr/we/wdata/sel
// and holds it until rsp_stb_o[c] pulses for one cycle; abort_i[c] withdraws
// interest (eligibility in IDLE, response suppression once granted). On the
// bus side wb_cyc_o/wb_stb_o stay high from grant until wb_ack_i (or timeout).
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_*_i, abort_i      : packed per-channel request fields, channel 0 in LSBs
//   rsp_stb_o/err/rdata   : completion pulse, timeout flag, shared read data
//   wb_*                  : Wishbone master
//   dbg_state_o/rr_ptr_o  : FSM state and round-robin pointer for observation
// ---------------------------------------------------------------------------
module mod_mem_arbiter
  import mod_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int XLEN    = SYS_XLEN,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            req_stb_i,
  input  logic [NUM_CH-1:0]            req_we_i,
  input  logic [NUM_CH*XLEN-1:0]       req_addr_i,
  input  logic [NUM_CH*XLEN-1:0]       req_wdata_i,
  input  logic [NUM_CH*XLEN/8-1:0]     req_sel_i,
  input  logic [NUM_CH-1:0]            abort_i,
  output logic [NUM_CH-1:0]            rsp_stb_o,
  output logic                         rsp_err_o,
  output logic [XLEN-1:0]              rsp_rdata_o,
  output logic [XLEN-1:0]              wb_adr_o,
  output logic [XLEN-1:0]              wb_dat_o,
  output logic [XLEN/8-1:0]            wb_sel_o,
  output logic                         wb_we_o,
  output logic                         wb_stb_o,
  output logic                         wb_cyc_o,
  input  logic [XLEN-1:0]              wb_dat_i,
  input  logic                         wb_ack_i,
  output arb_state_e                   dbg_state_o,
  output logic [grant_idx_width(NUM_CH)-1:0] dbg_rr_ptr_o
);

  localparam int   IDX_W   = grant_idx_width(NUM_CH);
  localparam int   BE_W    = XLEN / 8;
  localparam int   CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic MODE_RR = (RR_MODE != 0);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  arb_state_e          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx_q;
  logic [NUM_CH-1:0]   grant_oh_q;
  logic [NUM_CH-1:0]   rsp_stb_q;
  logic [CNT_W-1:0]    to_cnt;
  logic                abort_q;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [XLEN-1:0]     win_addr;
  logic [XLEN-1:0]     win_wdata;
  logic [BE_W-1:0]     win_sel;
  logic                win_we;
  logic                abort_hit;
  logic                timeout_hit;

  assign eligible = req_stb_i & ~abort_i;

  mod_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .mode  (MODE_RR),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_sel   = '0;
    win_we    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_grant[c]) begin
        win_addr  = req_addr_i[c*XLEN +: XLEN];
        win_wdata = req_wdata_i[c*XLEN +: XLEN];
        win_sel   = req_sel_i[c*BE_W +: BE_W];
        win_we    = req_we_i[c];
      end
    end
  end

  assign abort_hit   = |(abort_i & grant_oh_q);
  assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      rsp_stb_q   <= '0;
      to_cnt      <= '0;
      abort_q     <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
    end else begin
      rsp_stb_q <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_idx_q <= arb_idx;
            grant_oh_q  <= arb_grant;
            wb_adr_o    <= win_addr;
            wb_dat_o    <= win_wdata;
            wb_sel_o    <= win_sel;
            wb_we_o     <= win_we;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            to_cnt      <= '0;
            abort_q     <= 1'b0;
            state       <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (abort_hit) abort_q <= 1'b1;
          // An ack in the same cycle as the timeout wins: the data is real.
          if (wb_ack_i || timeout_hit) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_err_o   <= !wb_ack_i;
            rsp_rdata_o <= wb_ack_i ? wb_dat_i : '0;
            rsp_stb_q   <= (abort_q || abort_hit) ? '0 : grant_oh_q;
            state       <= ST_DONE;
          end else if (TIMEOUT > 0) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          rr_ptr  <= (grant_idx_q == LAST_CH) ? '0 : grant_idx_q + IDX_W'(1);
          abort_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // An abort arriving during the DONE cycle itself still kills the pulse.
  assign rsp_stb_o    = rsp_stb_q & ~abort_i;
  assign dbg_state_o  = state;
  assign dbg_rr_ptr_o = rr_ptr;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod_mem_arbiter
// Two arbiter instances: "a" (3 channels, round-robin, TIMEOUT=8) and
// "b" (2 channels, fixed priority, no timeout). Inputs are driven and outputs
// sampled on the falling clock edge; the bench plays the Wishbone slave.
// ---------------------------------------------------------------------------
module tb_mod_mem_arbiter;
  import mod_mem_arbiter_pkg::*;

  localparam int A_CH = 3;
  localparam int B_CH = 2;
  localparam int XW   = 32;
  localparam int BW   = XW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [XW-1:0] exp_q[$];

  // ---------------- instance a ----------------
  logic [A_CH-1:0]    a_req_stb, a_req_we, a_abort, a_rsp_stb;
  logic [A_CH*XW-1:0] a_req_addr, a_req_wdata;
  logic [A_CH*BW-1:0] a_req_sel;
  logic               a_rsp_err, a_wb_we, a_wb_stb, a_wb_cyc, a_wb_ack;
  logic [XW-1:0]      a_rsp_rdata, a_wb_adr, a_wb_dat, a_wb_dat_i;
  logic [BW-1:0]      a_wb_sel;
  arb_state_e         a_dbg_state;
  logic [1:0]         a_dbg_ptr;

  mod_mem_arbiter #(.NUM_CH(A_CH), .XLEN(XW), .RR_MODE(1), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_stb_i(a_req_stb), .req_we_i(a_req_we), .req_addr_i(a_req_addr),
    .req_wdata_i(a_req_wdata), .req_sel_i(a_req_sel), .abort_i(a_abort),
    .rsp_stb_o(a_rsp_stb), .rsp_err_o(a_rsp_err), .rsp_rdata_o(a_rsp_rdata),
    .wb_adr_o(a_wb_adr), .wb_dat_o(a_wb_dat), .wb_sel_o(a_wb_sel),
    .wb_we_o(a_wb_we), .wb_stb_o(a_wb_stb), .wb_cyc_o(a_wb_cyc),
    .wb_dat_i(a_wb_dat_i), .wb_ack_i(a_wb_ack),
    .dbg_state_o(a_dbg_state), .dbg_rr_ptr_o(a_dbg_ptr)
  );

  // ---------------- instance b ----------------
  logic [B_CH-1:0]    b_req_stb, b_req_we, b_abort, b_rsp_stb;
  logic [B_CH*XW-1:0] b_req_addr, b_req_wdata;
  logic [B_CH*BW-1:0] b_req_sel;
  logic               b_rsp_err, b_wb_we, b_wb_stb, b_wb_cyc, b_wb_ack;
  logic [XW-1:0]      b_rsp_rdata, b_wb_adr, b_wb_dat, b_wb_dat_i;
  logic [BW-1:0]      b_wb_sel;
  arb_state_e         b_dbg_state;
  logic [0:0]         b_dbg_ptr;

  mod_mem_arbiter #(.NUM_CH(B_CH), .XLEN(XW), .RR_MODE(0), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_stb_i(b_req_stb), .req_we_i(b_req_we), .req_addr_i(b_req_addr),
    .req_wdata_i(b_req_wdata), .req_sel_i(b_req_sel), .abort_i(b_abort),
    .rsp_stb_o(b_rsp_stb), .rsp_err_o(b_rsp_err), .rsp_rdata_o(b_rsp_rdata),
    .wb_adr_o(b_wb_adr), .wb_dat_o(b_wb_dat), .wb_sel_o(b_wb_sel),
    .wb_we_o(b_wb_we), .wb_stb_o(b_wb_stb), .wb_cyc_o(b_wb_cyc),
    .wb_dat_i(b_wb_dat_i), .wb_ack_i(b_wb_ack),
    .dbg_state_o(b_dbg_state), .dbg_rr_ptr_o(b_dbg_ptr)
  );

  // ---------------- reference model ----------------
  // Round-robin rule: first requesting channel at or after ptr, wrapping.
  function automatic int rr_pick(input logic [A_CH-1:0] mask, input int p);
    for (int i = 0; i < A_CH; i++) begin
      int c;
      c = (p + i) % A_CH;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    a_req_stb = '0; a_req_we = '0; a_abort = '0; a_req_addr = '0;
    a_req_wdata = '0; a_req_sel = '0; a_wb_ack = 1'b0; a_wb_dat_i = '0;
    b_req_stb = '0; b_req_we = '0; b_abort = '0; b_req_addr = '0;
    b_req_wdata = '0; b_req_sel = '0; b_wb_ack = 1'b0; b_wb_dat_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic a_set_req(input int c, input logic we, input logic [XW-1:0] addr,
                           input logic [XW-1:0] wdata, input logic [BW-1:0] sel);
    a_req_stb[c] = 1'b1;
    a_req_we[c]  = we;
    a_req_addr[c*XW +: XW]  = addr;
    a_req_wdata[c*XW +: XW] = wdata;
    a_req_sel[c*BW +: BW]   = sel;
  endtask

  task automatic b_set_req(input int c, input logic [XW-1:0] addr);
    b_req_stb[c] = 1'b1;
    b_req_addr[c*XW +: XW] = addr;
    b_req_sel[c*BW +: BW]  = 4'hF;
  endtask

  // Waits (bounded) for the first falling edge at which cyc is high.
  task automatic a_wait_cyc(output bit seen, output int n);
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (a_wb_cyc === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic b_wait_cyc(output bit seen, output int n);
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (b_wb_cyc === 1'b1) seen = 1'b1;
    end
  endtask

  // Called on the first BUS falling edge; returns on the DONE falling edge.
  task automatic a_ack(input int waits, input logic [XW-1:0] d);
    repeat (waits) @(negedge clk);
    a_wb_dat_i = d; a_wb_ack = 1'b1;
    @(negedge clk);
    a_wb_ack = 1'b0; a_wb_dat_i = $urandom;
  endtask

  task automatic b_ack(input logic [XW-1:0] d);
    b_wb_dat_i = d; b_wb_ack = 1'b1;
    @(negedge clk);
    b_wb_ack = 1'b0; b_wb_dat_i = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    a_req_stb = 3'b111;
    b_req_stb = 2'b11;
    @(negedge clk);
    checks++;
    if ({a_wb_cyc, a_wb_stb, a_wb_we} !== 3'b000) begin
      errors++; $display("FAIL reset_a_ctl: got %b expected 000", {a_wb_cyc, a_wb_stb, a_wb_we});
    end
    checks++;
    if ({a_wb_adr, a_wb_dat, a_wb_sel} !== '0) begin
      errors++; $display("FAIL reset_a_bus: got %h %h %h expected zeros", a_wb_adr, a_wb_dat, a_wb_sel);
    end
    checks++;
    if ({a_rsp_stb, a_rsp_err} !== 4'b0000 || a_rsp_rdata !== '0) begin
      errors++; $display("FAIL reset_a_rsp: got %b %b %h expected zeros", a_rsp_stb, a_rsp_err, a_rsp_rdata);
    end
    checks++;
    if (a_dbg_state !== ST_IDLE || a_dbg_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_a_fsm: got %0d ptr %0d expected IDLE ptr 0", a_dbg_state, a_dbg_ptr);
    end
    checks++;
    if ({b_wb_cyc, b_wb_stb, b_wb_we, b_rsp_stb, b_rsp_err} !== 6'b0 || b_rsp_rdata !== '0 ||
        {b_wb_adr, b_wb_dat, b_wb_sel} !== '0 || b_dbg_state !== ST_IDLE || b_dbg_ptr !== 1'b0) begin
      errors++; $display("FAIL reset_b: got cyc %b rsp %b err %b state %0d expected idle zeros",
                         b_wb_cyc, b_rsp_stb, b_rsp_err, b_dbg_state);
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_rr_alternate();
    bit seen; int n; int p; int exp_c; logic [XW-1:0] d;
    do_reset();
    p = 0;
    a_set_req(0, 1'b0, 32'h1000, 32'h0, 4'hF);
    a_set_req(1, 1'b0, 32'h1010, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      a_wait_cyc(seen, n);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rr_cyc_timeout: got no cyc expected cyc iter %0d", k);
        break;
      end
      if (k > 0) begin
        checks++;
        if (n !== 2) begin
          errors++; $display("FAIL rr_gap: got %0d expected 2 idle cycles", n);
        end
      end
      exp_c = rr_pick(a_req_stb, p);
      checks++;
      if (a_wb_adr !== 32'h1000 + 32'(exp_c * 16)) begin
        errors++; $display("FAIL rr_adr: got %h expected %h", a_wb_adr, 32'h1000 + 32'(exp_c * 16));
      end
      d = $urandom;
      a_ack(0, d);
      checks++;
      if (a_rsp_stb !== 3'(1 << exp_c) || a_rsp_rdata !== d) begin
        errors++; $display("FAIL rr_rsp: got %b %h expected %b %h", a_rsp_stb, a_rsp_rdata, 3'(1 << exp_c), d);
      end
      p = (exp_c + 1) % A_CH;
    end
    a_req_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    bit seen; int n;
    do_reset();
    b_set_req(0, 32'h2000);
    b_set_req(1, 32'h2004);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) b_req_stb[0] = 1'b0;
      b_wait_cyc(seen, n);
      checks++;
      if (!seen || b_wb_adr !== ((k < 4) ? 32'h2000 : 32'h2004)) begin
        errors++; $display("FAIL fixed_adr: got %h expected %h iter %0d", b_wb_adr,
                           (k < 4) ? 32'h2000 : 32'h2004, k);
      end
      b_ack(32'h5500 + 32'(k));
      checks++;
      if (b_rsp_stb !== ((k < 4) ? 2'b01 : 2'b10) || b_rsp_rdata !== 32'h5500 + 32'(k)) begin
        errors++; $display("FAIL fixed_rsp: got %b %h expected %b %h", b_rsp_stb, b_rsp_rdata,
                           (k < 4) ? 2'b01 : 2'b10, 32'h5500 + 32'(k));
      end
    end
    b_req_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_wait_stable();
    bit seen; int n;
    a_set_req(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    a_wait_cyc(seen, n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({a_wb_cyc, a_wb_stb, a_wb_we} !== 3'b111 || a_wb_adr !== 32'h100 ||
          a_wb_dat !== 32'hDEAD_BEEF || a_wb_sel !== 4'hF || a_rsp_stb !== 3'b000) begin
        errors++; $display("FAIL wait_stable: got cyc %b adr %h dat %h sel %h rsp %b expected 1 100 deadbeef f 000 cycle %0d",
                           a_wb_cyc, a_wb_adr, a_wb_dat, a_wb_sel, a_rsp_stb, i);
      end
      if (i == 4) begin a_wb_ack = 1'b1; a_wb_dat_i = '0; end
      @(negedge clk);
    end
    a_wb_ack = 1'b0;
    a_req_stb[1] = 1'b0;
    checks++;
    if (a_wb_cyc !== 1'b0 || a_rsp_stb !== 3'b010 || a_rsp_err !== 1'b0) begin
      errors++; $display("FAIL wait_done: got cyc %b rsp %b err %b expected 0 010 0", a_wb_cyc, a_rsp_stb, a_rsp_err);
    end
    @(negedge clk);
    checks++;
    if (a_rsp_stb !== 3'b000) begin
      errors++; $display("FAIL wait_pulse_width: got %b expected 000", a_rsp_stb);
    end
  endtask

  task automatic test_abort();
    bit seen; int n; logic [XW-1:0] d;
    a_set_req(0, 1'b0, 32'h200, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    a_abort[0] = 1'b1;
    a_req_stb[0] = 1'b0;
    @(negedge clk);
    a_abort[0] = 1'b0;
    checks++;
    if (a_wb_cyc !== 1'b1 || a_wb_stb !== 1'b1) begin
      errors++; $display("FAIL abort_cyc_held: got %b%b expected 11", a_wb_cyc, a_wb_stb);
    end
    a_ack(0, 32'h1234_5678);
    checks++;
    if (a_wb_cyc !== 1'b0 || a_rsp_stb !== 3'b000) begin
      errors++; $display("FAIL abort_suppress: got cyc %b rsp %b expected 0 000", a_wb_cyc, a_rsp_stb);
    end
    @(negedge clk);
    checks++;
    if (a_rsp_stb !== 3'b000) begin
      errors++; $display("FAIL abort_late_rsp: got %b expected 000", a_rsp_stb);
    end
    a_set_req(0, 1'b0, 32'h204, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    checks++;
    if (!seen || a_wb_adr !== 32'h204) begin
      errors++; $display("FAIL abort_next_adr: got %h expected 204", a_wb_adr);
    end
    d = $urandom;
    a_ack(1, d);
    a_req_stb[0] = 1'b0;
    checks++;
    if (a_rsp_stb !== 3'b001 || a_rsp_rdata !== d) begin
      errors++; $display("FAIL abort_next_rsp: got %b %h expected 001 %h", a_rsp_stb, a_rsp_rdata, d);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_other();
    bit seen; int n; int hi;
    a_abort[1] = 1'b1;
    a_set_req(1, 1'b0, 32'h310, 32'h0, 4'hF);
    hi = 0;
    repeat (4) begin @(negedge clk); if (a_wb_cyc === 1'b1) hi++; end
    checks++;
    if (hi !== 0) begin
      errors++; $display("FAIL abort_ineligible: got %0d cyc cycles expected 0", hi);
    end
    a_set_req(2, 1'b0, 32'h320, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    checks++;
    if (!seen || a_wb_adr !== 32'h320) begin
      errors++; $display("FAIL abort_other_adr: got %h expected 320", a_wb_adr);
    end
    a_ack(2, 32'hA5A5_0001);
    a_req_stb[2] = 1'b0;
    a_abort[1] = 1'b0;
    checks++;
    if (a_rsp_stb !== 3'b100 || a_rsp_rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL abort_other_rsp: got %b %h expected 100 a5a50001", a_rsp_stb, a_rsp_rdata);
    end
    a_wait_cyc(seen, n);
    checks++;
    if (!seen || a_wb_adr !== 32'h310) begin
      errors++; $display("FAIL abort_release_adr: got %h expected 310", a_wb_adr);
    end
    a_ack(0, 32'h0);
    a_req_stb[1] = 1'b0;
    checks++;
    if (a_rsp_stb !== 3'b010) begin
      errors++; $display("FAIL abort_release_rsp: got %b expected 010", a_rsp_stb);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen; int n; int hi;
    a_set_req(2, 1'b0, 32'h400, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    hi = seen ? 1 : 0;
    while (a_wb_cyc === 1'b1 && hi < 20) begin
      @(negedge clk);
      if (a_wb_cyc === 1'b1) hi++;
    end
    a_req_stb[2] = 1'b0;
    checks++;
    if (hi !== 8) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected 8", hi);
    end
    checks++;
    if (a_rsp_stb !== 3'b100 || a_rsp_err !== 1'b1 || a_rsp_rdata !== '0) begin
      errors++; $display("FAIL timeout_rsp: got %b err %b data %h expected 100 1 0", a_rsp_stb, a_rsp_err, a_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    bit seen; int n;
    a_set_req(0, 1'b0, 32'h500, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    a_ack(0, 32'h1);
    a_req_stb[0] = 1'b0;
    a_set_req(1, 1'b0, 32'h504, 32'h0, 4'hF);
    a_wait_cyc(seen, n);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_wb_cyc !== 1'b0 || a_wb_stb !== 1'b0 || a_dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_async: got cyc %b stb %b state %0d expected 0 0 IDLE", a_wb_cyc, a_wb_stb, a_dbg_state);
    end
    a_set_req(0, 1'b0, 32'h500, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (a_rsp_stb !== 3'b000 || a_dbg_ptr !== 2'd0) begin
      errors++; $display("FAIL rst_state: got rsp %b ptr %0d expected 000 0", a_rsp_stb, a_dbg_ptr);
    end
    rst = 1'b0;
    a_wait_cyc(seen, n);
    checks++;
    if (!seen || a_wb_adr !== 32'h500) begin
      errors++; $display("FAIL rst_first_grant: got %h expected 500", a_wb_adr);
    end
    a_ack(0, 32'h2);
    a_req_stb = '0;
    checks++;
    if (a_rsp_stb !== 3'b001) begin
      errors++; $display("FAIL rst_first_rsp: got %b expected 001", a_rsp_stb);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit seen; int n; int p; int exp_c;
    logic [A_CH-1:0] pend;
    logic [XW-1:0] m_addr[A_CH], m_wdata[A_CH], d, exp_d;
    logic [BW-1:0] m_sel[A_CH];
    logic          m_we[A_CH];
    do_reset();
    p = 0;
    pend = '0;
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < A_CH; c++) begin
        if (!pend[c] && ($urandom_range(0, 1) == 1 || (pend == '0 && c == A_CH - 1))) begin
          pend[c]     = 1'b1;
          m_addr[c]   = $urandom;
          m_wdata[c]  = $urandom;
          m_sel[c]    = 4'($urandom_range(1, 15));
          m_we[c]     = 1'($urandom_range(0, 1));
          a_set_req(c, m_we[c], m_addr[c], m_wdata[c], m_sel[c]);
        end
      end
      exp_c = rr_pick(pend, p);
      a_wait_cyc(seen, n);
      checks++;
      if (!seen || {a_wb_adr, a_wb_dat, a_wb_sel, a_wb_we} !==
                   {m_addr[exp_c], m_wdata[exp_c], m_sel[exp_c], m_we[exp_c]}) begin
        errors++; $display("FAIL rand_bus: got adr %h dat %h sel %h we %b expected %h %h %h %b (ch %0d)",
                           a_wb_adr, a_wb_dat, a_wb_sel, a_wb_we, m_addr[exp_c], m_wdata[exp_c],
                           m_sel[exp_c], m_we[exp_c], exp_c);
        if (!seen) break;
      end
      d = $urandom;
      exp_q.push_back(d);
      a_ack($urandom_range(0, 3), d);
      exp_d = exp_q.pop_front();
      checks++;
      if (a_rsp_stb !== 3'(1 << exp_c) || a_rsp_rdata !== exp_d || a_rsp_err !== 1'b0) begin
        errors++; $display("FAIL rand_rsp: got %b %h err %b expected %b %h 0",
                           a_rsp_stb, a_rsp_rdata, a_rsp_err, 3'(1 << exp_c), exp_d);
      end
      pend[exp_c] = 1'b0;
      a_req_stb[exp_c] = 1'b0;
      p = (exp_c + 1) % A_CH;
    end
    a_req_stb = '0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rr_alternate();
    test_fixed_priority();
    test_wait_stable();
    test_abort();
    test_abort_other();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_mem_arbiter.md
MOD_MEM_ARBITER -- requirements
Module: mod_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requester channels, range 1..8.
REQ-002 SHALL have parameter XLEN, default 32: address/data width.
REQ-003 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest).
REQ-004 SHALL have parameter TIMEOUT, default 0: ack timeout in cycles; 0 disables timeout.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_stb_i  input  NUM_CH  per-channel request, level, held until rsp_stb_o.
REQ-008 SHALL have port req_we_i  input  NUM_CH  per-channel write flag.
REQ-009 SHALL have port req_addr_i  input  NUM_CH*XLEN  packed addresses, channel 0 in LSBs.
REQ-010 SHALL have port req_wdata_i  input  NUM_CH*XLEN  packed write data.
REQ-011 SHALL have port req_sel_i  input  NUM_CH*XLEN/8  packed byte enables.
REQ-012 SHALL have port abort_i  input  NUM_CH  per-channel cancel (e.g. fetch flush on taken branch).
REQ-013 SHALL have port rsp_stb_o  output  NUM_CH  one-cycle completion pulse.
REQ-014 SHALL have port rsp_err_o  output  1  completion was a timeout; valid with rsp_stb_o.
REQ-015 SHALL have port rsp_rdata_o  output  XLEN  read data, shared by all channels, valid with rsp_stb_o.
REQ-016 SHALL have ports wb_adr_o/wb_dat_o (XLEN out), wb_sel_o (XLEN/8 out), wb_we_o/wb_stb_o/wb_cyc_o (1 out), wb_dat_i (XLEN in), wb_ack_i (1 in): Wishbone B4 classic master.

Function
REQ-017 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE.
REQ-018 In IDLE, channel c SHALL be eligible when req_stb_i[c] && !abort_i[c]; with none eligible, stay IDLE.
REQ-019 RR_MODE=0: lowest eligible index SHALL win; RR_MODE=1: first eligible index at or after rr_ptr (wrapping at NUM_CH) SHALL win.
REQ-020 On a grant, addr/we/wdata/sel of the winner and the grant index SHALL be registered; next state BUS.
REQ-021 In BUS, wb_cyc_o=wb_stb_o=1 and wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o SHALL come only from registers, stable for the whole cycle.
REQ-022 In BUS, wb_ack_i=1 SHALL capture wb_dat_i into rsp_rdata_o, drop cyc/stb next cycle, go DONE.
REQ-023 TIMEOUT>0: a counter SHALL count BUS cycles; reaching TIMEOUT without ack SHALL go DONE with rsp_err_o=1, rsp_rdata_o=0.
REQ-024 In DONE, rsp_stb_o[grant]=1 for exactly one cycle unless aborted; rr_ptr <= (grant+1) mod NUM_CH; next state IDLE.
REQ-025 Zero-wait slave: request seen in IDLE at cycle N -> wb_cyc_o at N+1 -> rsp_stb_o at N+2; back-to-back throughput one transfer per 3 cycles.
REQ-026 abort_i[grant] asserted in BUS or DONE SHALL be latched; bus cycle SHALL still complete (no early cyc drop) but rsp_stb_o SHALL be suppressed.
REQ-027 abort_i on a non-granted channel SHALL only affect its eligibility.
REQ-028 Requests SHALL be sampled only in IDLE; request changes during BUS/DONE SHALL not alter the transfer in flight.
REQ-029 At most one rsp_stb_o bit SHALL be high in any cycle.

Reset
REQ-030 rst_i SHALL immediately (asynchronously) force state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o/wb_sel_o=0, rsp_stb_o=0, rsp_err_o=0, rsp_rdata_o=0, rr_ptr=0, timeout counter=0, abort latch=0.
REQ-031 Reset mid-BUS SHALL abandon the transfer with no response; first grant after release SHALL follow REQ-019 from rr_ptr=0.

Structure
REQ-032 State enum and grant-index width ($clog2(NUM_CH), min 1) SHALL live in the shared system package alongside existing XLEN/BYTEENABLE_WIDTH defines.
REQ-033 Arbitration SHALL be a combinational sub-module mod_rr_arbiter (req, ptr, mode -> one-hot grant, index).

Verification
REQ-034 NUM_CH=2, RR_MODE=1, both req_stb_i held, zero-wait ack -> grants alternate 0,1,0,1; rsp_stb_o every 3 cycles.
REQ-035 RR_MODE=0, both held -> channel 0 granted repeatedly, channel 1 never until req_stb_i[0]=0.
REQ-036 Ch1 write addr 0x100, wdata 0xDEADBEEF, sel 0xF, ack after 4 wait cycles -> adr/dat/sel stable 5 cycles, rsp_stb_o[1] one cycle after ack.
REQ-037 Ch0 read granted, abort_i[0] pulsed in BUS, ack returns 0x12345678 -> cyc held to ack, rsp_stb_o stays 0, next request serviced normally.
REQ-038 TIMEOUT=8, no ack -> cyc drops after 8 BUS cycles, rsp_stb_o pulses with rsp_err_o=1, rsp_rdata_o=0.
REQ-039 rst_i asserted mid-BUS off-edge -> wb_cyc_o low same cycle, no rsp_stb_o, rr_ptr=0 after release.
